traffic_phase_sched: RTL and testbench

Parameterised phase scheduler for a two-road signalised intersection (main road = signal group 1, side road = group 2).
- Sequences green/yellow/all-red phases from a prescaled phase timer.
- Arbitrates side-road vehicle requests against a main-road minimum green.
- Supports flash mode and a test-accelerate input.
- Drives the six lamp outputs directly from registers, with the phase code exported for observation.

---
 rtl/traffic_phase_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_traffic_phase_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched
//   Phase scheduler for a two-road signalised intersection. Group 1 is the
//   main road, group 2 the side road. A prescaled phase timer sequences
//   green / yellow / all-red phases. Side-road requests are held until the
//   main-road minimum green has elapsed. Flash mode overrides every timed
//   transition.
//
// Optional feature: define PED_WALK_EN to add the pedestrian walk interval.
// That build adds the PREQ, WALK and PACK ports and the T_WALK parameter.
//
// Ports
//   CK     in   clock, rising edge
//   CLR    in   asynchronous active-low reset
//   TEST   in   1 = timer ticks every cycle (prescaler bypassed)
//   FM     in   flash mode request (level)
//   SREQ   in   side-road vehicle sensor (level or pulse)
//   GRN1/YLW1/RED1  out  main-road lamps (registered)
//   GRN2/YLW2/RED2  out  side-road lamps (registered)
//   PHASE  out  [2:0] current state code (registered)
//   PREQ   in   pedestrian button          (PED_WALK_EN only)
//   WALK   out  pedestrian walk lamp       (PED_WALK_EN only)
//   PACK   out  one-cycle acknowledge      (PED_WALK_EN only)

module traffic_phase_sched #(
    parameter int TW         = 5,
    parameter int PRESCALE   = 4,
    parameter int T_MIN_GRN  = 8,
    parameter int T_SIDE_GRN = 6,
    parameter int T_YLW      = 3,
    parameter int T_RED      = 2
`ifdef PED_WALK_EN
    ,
    parameter int T_WALK     = 4
`endif
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic       TEST,
    input  logic       FM,
    input  logic       SREQ,
    output logic       GRN1,
    output logic       YLW1,
    output logic       RED1,
    output logic       GRN2,
    output logic       YLW2,
    output logic       RED2,
    output logic [2:0] PHASE
`ifdef PED_WALK_EN
    ,
    input  logic       PREQ,
    output logic       WALK,
    output logic       PACK
`endif
);

    typedef enum logic [2:0] {
        MAIN_GRN = 3'd0,
        MAIN_YLW = 3'd1,
        ALL_RED1 = 3'd2,
        SIDE_GRN = 3'd3,
        SIDE_YLW = 3'd4,
        ALL_RED2 = 3'd5,
        FLASH    = 3'd6
    } state_t;

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
    localparam logic [TW-1:0] TMR_MAX   = '1;
    localparam logic [TW-1:0] MIN_LAST  = TW'(T_MIN_GRN - 1);
    localparam logic [TW-1:0] SIDE_LAST = TW'(T_SIDE_GRN - 1);
    localparam logic [TW-1:0] YLW_LAST  = TW'(T_YLW - 1);
    localparam logic [TW-1:0] RED_LAST  = TW'(T_RED - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          tick;
    logic          chg;
    logic          entering_side;
    logic          sreq_l;
    logic          req;
    logic          blink, blink_nxt;
    logic          grn1_nxt, ylw1_nxt, red1_nxt;
    logic          grn2_nxt, ylw2_nxt, red2_nxt;

`ifdef PED_WALK_EN
    localparam logic [TW:0] WALK_LEN = (TW+1)'(T_WALK);
    logic preq_l;
    logic walk_nxt;
    assign req = sreq_l | preq_l;
`else
    assign req = sreq_l;
`endif

    assign tick = TEST | (pre == PRE_MAX);

    // Next-state decode; FM has priority over every timed transition.
    always_comb begin
        state_nxt = state;
        if (FM && state != FLASH) begin
            state_nxt = FLASH;
        end else begin
            case (state)
                MAIN_GRN: if (tick && tmr >= MIN_LAST && req)  state_nxt = MAIN_YLW;
                MAIN_YLW: if (tick && tmr == YLW_LAST)         state_nxt = ALL_RED1;
                ALL_RED1: if (tick && tmr == RED_LAST)         state_nxt = SIDE_GRN;
                SIDE_GRN: if (tick && tmr == SIDE_LAST)        state_nxt = SIDE_YLW;
                SIDE_YLW: if (tick && tmr == YLW_LAST)         state_nxt = ALL_RED2;
                ALL_RED2: if (tick && tmr == RED_LAST)         state_nxt = MAIN_GRN;
                FLASH:    if (!FM)                             state_nxt = ALL_RED2;
                default:                                       state_nxt = ALL_RED2;
            endcase
        end
    end

    // Timer, prescaler and blink bookkeeping.
    always_comb begin
        chg           = (state_nxt != state);
        entering_side = (state_nxt == SIDE_GRN) && (state != SIDE_GRN);

        pre_nxt = (chg || pre == PRE_MAX) ? '0 : pre + 1'b1;

        if (chg)
            tmr_nxt = '0;
        else if (tick && tmr != TMR_MAX)
            tmr_nxt = tmr + 1'b1;
        else
            tmr_nxt = tmr;

        blink_nxt = blink;
        if (state_nxt == FLASH) begin
            if (state != FLASH)
                blink_nxt = 1'b1;
            else if (tick)
                blink_nxt = ~blink;
        end
    end

    // Lamps are decoded from the next state so they move on the same edge
    // as PHASE; a single decoded state keeps GRN1/GRN2 exclusive.
    always_comb begin
        grn1_nxt = 1'b0;
        ylw1_nxt = 1'b0;
        red1_nxt = 1'b0;
        grn2_nxt = 1'b0;
        ylw2_nxt = 1'b0;
        red2_nxt = 1'b0;
        if (state_nxt == FLASH) begin
            ylw1_nxt = blink_nxt;
            red2_nxt = blink_nxt;
        end else begin
            grn1_nxt = (state_nxt == MAIN_GRN);
            ylw1_nxt = (state_nxt == MAIN_YLW);
            red1_nxt = !(state_nxt == MAIN_GRN || state_nxt == MAIN_YLW);
            grn2_nxt = (state_nxt == SIDE_GRN);
            ylw2_nxt = (state_nxt == SIDE_YLW);
            red2_nxt = !(state_nxt == SIDE_GRN || state_nxt == SIDE_YLW);
        end
    end

`ifdef PED_WALK_EN
    // WALK can only stay high inside the SIDE_GRN it was granted on; once
    // it drops it remains low for the rest of that phase.
    always_comb begin
        walk_nxt = (state_nxt == SIDE_GRN)
                && (entering_side ? preq_l : WALK)
                && ({1'b0, tmr_nxt} < WALK_LEN);
    end
`endif

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            state  <= ALL_RED2;
            PHASE  <= 3'd5;
            pre    <= '0;
            tmr    <= '0;
            sreq_l <= 1'b0;
            blink  <= 1'b1;
            GRN1   <= 1'b0;
            YLW1   <= 1'b0;
            RED1   <= 1'b1;
            GRN2   <= 1'b0;
            YLW2   <= 1'b0;
            RED2   <= 1'b1;
        end else begin
            state  <= state_nxt;
            PHASE  <= state_nxt;
            pre    <= pre_nxt;
            tmr    <= tmr_nxt;
            blink  <= blink_nxt;
            GRN1   <= grn1_nxt;
            YLW1   <= ylw1_nxt;
            RED1   <= red1_nxt;
            GRN2   <= grn2_nxt;
            YLW2   <= ylw2_nxt;
            RED2   <= red2_nxt;
            // The clear on SIDE_GRN entry wins over a simultaneous set.
            if (entering_side)
                sreq_l <= 1'b0;
            else if (SREQ && state != SIDE_GRN)
                sreq_l <= 1'b1;
        end
    end

`ifdef PED_WALK_EN
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            preq_l <= 1'b0;
            WALK   <= 1'b0;
            PACK   <= 1'b0;
        end else begin
            WALK <= walk_nxt;
            PACK <= entering_side && preq_l;
            if (entering_side)
                preq_l <= 1'b0;
            else if (PREQ && state != SIDE_GRN)
                preq_l <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed testbench for traffic_phase_sched (default parameters).
// Inputs are driven and outputs sampled on the falling edge of CK.

module tb_traffic_phase_sched;

    logic       CK;
    logic       CLR;
    logic       TEST;
    logic       FM;
    logic       SREQ;
    logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
    logic [2:0] PHASE;
`ifdef PED_WALK_EN
    logic       PREQ;
    logic       WALK;
    logic       PACK;
`endif

    int n_pass  = 0;
    int n_total = 0;

    traffic_phase_sched dut (
        .CK    (CK),
        .CLR   (CLR),
        .TEST  (TEST),
        .FM    (FM),
        .SREQ  (SREQ),
        .GRN1  (GRN1),
        .YLW1  (YLW1),
        .RED1  (RED1),
        .GRN2  (GRN2),
        .YLW2  (YLW2),
        .RED2  (RED2),
        .PHASE (PHASE)
`ifdef PED_WALK_EN
        ,
        .PREQ  (PREQ),
        .WALK  (WALK),
        .PACK  (PACK)
`endif
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Expected {PHASE, GRN1, YLW1, RED1, GRN2, YLW2, RED2} for a phase code.
    function automatic logic [8:0] exp_of(input int ph, input logic blink);
        case (ph)
            0:       return {3'd0, 6'b100_001};
            1:       return {3'd1, 6'b010_001};
            2:       return {3'd2, 6'b001_001};
            3:       return {3'd3, 6'b001_100};
            4:       return {3'd4, 6'b001_010};
            5:       return {3'd5, 6'b001_001};
            default: return {3'd6, 1'b0, blink, 1'b0, 1'b0, 1'b0, blink};
        endcase
    endfunction

    function automatic logic [8:0] obs();
        return {PHASE, GRN1, YLW1, RED1, GRN2, YLW2, RED2};
    endfunction

    task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, o, e);
    endtask

    // Check that phase ph is shown for the next n falling edges.
    task automatic run(input string tag, input int ph, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CK);
            chk($sformatf("%s[%0d]", tag, i), obs(), exp_of(ph, 1'b0));
            chk($sformatf("%s_mutex[%0d]", tag, i), {8'd0, GRN1 & GRN2}, 9'd0);
        end
    endtask

    initial begin
        CLR  = 1'b1;
        TEST = 1'b1;
        FM   = 1'b0;
        SREQ = 1'b0;
`ifdef PED_WALK_EN
        PREQ = 1'b0;
`endif
        // Asynchronous reset before any clock edge.
        #2 CLR = 1'b0;
        #1 chk("async_reset", obs(), exp_of(5, 1'b0));
        @(negedge CK);
        chk("reset_held", obs(), exp_of(5, 1'b0));
        CLR = 1'b1;

        // No request: all-red clearance, then main green holds.
        run("startup_ar2", 5, 1);
        run("main_hold", 0, 100);

        // Request after a long main green (timer saturated): one edge to
        // latch the request, then leave at once.
        SREQ = 1'b1;
        run("latch_edge", 0, 1);
        SREQ = 1'b0;
        run("c1_mylw", 1, 3);
        run("c1_ar1", 2, 2);
        run("c1_sgrn", 3, 6);
        run("c1_sylw", 4, 3);
        run("c1_ar2", 5, 2);

        // One-cycle pulse early in a fresh main green: minimum green rules.
        run("c2_mgrn_a", 0, 1);
        SREQ = 1'b1;
        run("c2_mgrn_b", 0, 1);
        SREQ = 1'b0;
        run("c2_mgrn_c", 0, 6);
        run("c2_mylw", 1, 3);
        run("c2_ar1", 2, 2);

        // Flash request during side green.
        run("c2_sgrn", 3, 3);
        FM = 1'b1;
        @(negedge CK);
        chk("flash_entry", obs(), exp_of(6, 1'b1));
        @(negedge CK);
        chk("flash_blink1", obs(), exp_of(6, 1'b0));
        @(negedge CK);
        chk("flash_blink2", obs(), exp_of(6, 1'b1));
        @(negedge CK);
        chk("flash_blink3", obs(), exp_of(6, 1'b0));
        FM = 1'b0;
        run("flash_exit_ar2", 5, 2);

        // Prescaled timing with request held.
        run("p_mgrn_a", 0, 1);
        TEST = 1'b0;
        SREQ = 1'b1;
        run("p_mgrn_b", 0, 31);
        run("p_mylw", 1, 12);
        run("p_ar1", 2, 8);
        run("p_sgrn", 3, 24);
        run("p_sylw", 4, 12);
        run("p_ar2", 5, 8);

        // Request latched again after side green; back to TEST mode.
        run("t_mgrn_a", 0, 1);
        TEST = 1'b1;
        SREQ = 1'b0;
        run("t_mgrn_b", 0, 7);
        run("t_mylw", 1, 3);
        run("t_ar1", 2, 2);
        run("t_sgrn", 3, 6);
        run("t_sylw", 4, 1);

        // Asynchronous reset mid side yellow with a request pending.
        SREQ = 1'b1;
        @(posedge CK);
        #3 CLR = 1'b0;
        #1 chk("mid_reset", obs(), exp_of(5, 1'b0));
        @(negedge CK);
        chk("mid_reset_held", obs(), exp_of(5, 1'b0));
        SREQ = 1'b0;
        CLR  = 1'b1;
        run("r_ar2", 5, 1);
        run("r_main_hold", 0, 20);

`ifdef PED_WALK_EN
        // Pedestrian request: walk for the first T_WALK side-green ticks.
        PREQ = 1'b1;
        run("ped_latch", 0, 1);
        PREQ = 1'b0;
        run("ped_mylw", 1, 3);
        run("ped_ar1", 2, 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge CK);
            chk($sformatf("ped_sgrn[%0d]", i), obs(), exp_of(3, 1'b0));
            chk($sformatf("ped_walk_pack[%0d]", i), {7'd0, WALK, PACK},
                {7'd0, (i < 4) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0});
        end
        run("ped_sylw", 4, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
